l2_req_arbiter: RTL and testbench

L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

---
 rtl/l2_req_arbiter.sv | 125 ++++++++++++
 tb/tb_l2_req_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_req_arbiter.sv
// Four-core round-robin front end for a shared L2: grants one request at a time,
// presents it to the L2 for L2_LAT cycles, returns data and broadcasts invalidates.
module l2_req_arbiter #(
    parameter int L2_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [3:0]   req_we,
    input  logic [127:0] req_addr,
    input  logic [255:0] req_wdata,
    output logic [3:0]   gnt,
    output logic [3:0]   rsp_valid,
    output logic [63:0]  rsp_data,
    output logic [63:0]  l2_in,
    output logic [1:0]   l2_mode,
    output logic [31:0]  l2_st,
    output logic         l2_ch,
    output logic [1:0]   l2_procinfo,
    input  logic [63:0]  l2_out,
    input  logic [3:0]   l2_sprocinfo,
    output logic         inv_valid,
    output logic [3:0]   inv_mask,
    output logic [31:0]  inv_addr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [3:0]  r_cnt;
    logic [1:0]  r_idx;
    logic        r_we;
    logic [31:0] r_addr;

    logic [1:0]  w_cand;
    logic [1:0]  w_winner;
    logic        w_found;

    // Scan upward from the pointer, wrapping 3 -> 0; first requester wins.
    always_comb begin
        w_cand   = r_ptr;
        w_winner = r_ptr;
        w_found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_cand = r_ptr + 2'(i);
            if (!w_found && req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    assign gnt   = (rst_n && (r_state == S_IDLE) && w_found) ? (4'b0001 << w_winner) : 4'b0000;
    assign l2_ch = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_cnt       <= 4'd0;
            r_idx       <= 2'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            rsp_valid   <= 4'd0;
            rsp_data    <= 64'd0;
            l2_in       <= 64'd0;
            l2_mode     <= 2'b01;
            l2_st       <= 32'd0;
            l2_procinfo <= 2'd0;
            inv_valid   <= 1'b0;
            inv_mask    <= 4'd0;
            inv_addr    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx       <= w_winner;
                        r_we        <= req_we[w_winner];
                        r_addr      <= req_addr[{w_winner, 5'd0} +: 32];
                        l2_mode     <= req_we[w_winner] ? 2'b11 : 2'b00;
                        l2_st       <= req_addr[{w_winner, 5'd0} +: 32];
                        l2_in       <= req_wdata[{w_winner, 6'd0} +: 64];
                        l2_procinfo <= w_winner;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 4'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // L2 results are sampled on the edge that ends the last WAIT cycle.
                    if (r_cnt == 4'(L2_LAT - 1)) begin
                        r_state   <= S_RESP;
                        l2_mode   <= 2'b01;
                        rsp_valid <= 4'b0001 << r_idx;
                        if (r_we) begin
                            inv_valid <= 1'b1;
                            inv_mask  <= l2_sprocinfo & ~(4'b0001 << r_idx);
                            inv_addr  <= r_addr;
                        end else begin
                            rsp_data <= l2_out;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    rsp_valid <= 4'd0;
                    inv_valid <= 1'b0;
                    r_ptr     <= r_idx + 2'd1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed bench for l2_req_arbiter: reset values, round-robin order and spacing,
// table of complete read/write transactions, and reset during WAIT.
module tb_l2_req_arbiter;

    localparam int L2_LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [3:0]   req_we;
    logic [127:0] req_addr;
    logic [255:0] req_wdata;
    logic [3:0]   gnt;
    logic [3:0]   rsp_valid;
    logic [63:0]  rsp_data;
    logic [63:0]  l2_in;
    logic [1:0]   l2_mode;
    logic [31:0]  l2_st;
    logic         l2_ch;
    logic [1:0]   l2_procinfo;
    logic [63:0]  l2_out;
    logic [3:0]   l2_sprocinfo;
    logic         inv_valid;
    logic [3:0]   inv_mask;
    logic [31:0]  inv_addr;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [3:0]  req;
        logic [1:0]  idx;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] l2out;
        logic [3:0]  spi;
        logic [3:0]  expGnt;
        logic [3:0]  expMask;
    } vec_t;

    l2_req_arbiter #(.L2_LAT(L2_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .l2_in(l2_in),
        .l2_mode(l2_mode), .l2_st(l2_st), .l2_ch(l2_ch),
        .l2_procinfo(l2_procinfo), .l2_out(l2_out), .l2_sprocinfo(l2_sprocinfo),
        .inv_valid(inv_valid), .inv_mask(inv_mask), .inv_addr(inv_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Non-winning cores carry distinctive junk so a wrong capture index shows up.
    task automatic applyStimulus(input logic [3:0] r, input logic wr, input logic [1:0] idx,
                                 input logic [31:0] addr, input logic [63:0] wdata);
        logic [3:0] oneHot;
        oneHot = 4'b0001 << idx;
        req    = r;
        req_we = wr ? oneHot : ~oneHot;
        for (int k = 0; k < 4; k++) begin
            req_addr[32*k +: 32]  = (k == int'(idx)) ? addr  : (32'hBAD0_0000 | 32'(k));
            req_wdata[64*k +: 64] = (k == int'(idx)) ? wdata : (64'hBAD0_BAD0_0000_0000 | 64'(k));
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        req   = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        nextCycle();
    endtask

    task automatic runVector(input vec_t v, input int n);
        string tag;
        tag = $sformatf("v%0d", n);
        applyStimulus(v.req, v.wr, v.idx, v.addr, v.wdata);
        l2_out       = 64'hFFFF_0000_FFFF_0000;
        l2_sprocinfo = ~v.spi;
        @(negedge clk);
        checkOutput({tag, "_gnt"}, 64'(gnt), 64'(v.expGnt));

        nextCycle();
        req = 4'd0;
        @(negedge clk);
        checkOutput({tag, "_issue_mode"}, 64'(l2_mode), v.wr ? 64'h3 : 64'h0);
        checkOutput({tag, "_issue_st"}, 64'(l2_st), 64'(v.addr));
        checkOutput({tag, "_issue_in"}, l2_in, v.wdata);
        checkOutput({tag, "_issue_procinfo"}, 64'(l2_procinfo), 64'(v.idx));
        checkOutput({tag, "_issue_ch"}, 64'(l2_ch), 64'h0);

        for (int w = 0; w < L2_LAT; w++) begin
            nextCycle();
            req = ~v.expGnt;
            if (w == L2_LAT - 1) begin
                l2_out       = v.l2out;
                l2_sprocinfo = v.spi;
            end
            @(negedge clk);
            checkOutput({tag, "_wait_gnt"}, 64'(gnt), 64'h0);
            checkOutput({tag, "_wait_mode"}, 64'(l2_mode), v.wr ? 64'h3 : 64'h0);
            checkOutput({tag, "_wait_st"}, 64'(l2_st), 64'(v.addr));
            checkOutput({tag, "_wait_rsp"}, 64'(rsp_valid), 64'h0);
        end

        nextCycle();
        req          = 4'd0;
        l2_out       = 64'hFFFF_0000_FFFF_0000;
        l2_sprocinfo = ~v.spi;
        @(negedge clk);
        checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(v.expGnt));
        checkOutput({tag, "_rsp_mode"}, 64'(l2_mode), 64'h1);
        checkOutput({tag, "_inv_valid"}, 64'(inv_valid), 64'(v.wr));
        if (v.wr) begin
            checkOutput({tag, "_inv_mask"}, 64'(inv_mask), 64'(v.expMask));
            checkOutput({tag, "_inv_addr"}, 64'(inv_addr), 64'(v.addr));
        end else begin
            checkOutput({tag, "_rsp_data"}, rsp_data, v.l2out);
        end

        nextCycle();
        @(negedge clk);
        checkOutput({tag, "_post_rsp"}, 64'(rsp_valid), 64'h0);
        checkOutput({tag, "_post_inv"}, 64'(inv_valid), 64'h0);
        nextCycle();
    endtask

    initial begin
        vec_t       vecs[8];
        logic [3:0] rrOrder[5];
        int         cyc;
        int         nGrant;
        int         lastCyc;
        int         firstCyc;
        logic       sawRsp;

        vecs[0] = '{4'b0100, 2'd2, 1'b0, 32'h0000_0013, 64'h0, 64'hDEAD_BEEF_0000_0001, 4'b0000, 4'b0100, 4'b0000};
        vecs[1] = '{4'b1001, 2'd3, 1'b0, 32'h0000_3000, 64'h33, 64'h0123_4567_89AB_CDEF, 4'b0000, 4'b1000, 4'b0000};
        vecs[2] = '{4'b1001, 2'd0, 1'b1, 32'h0000_0021, 64'h1111, 64'h0, 4'b1011, 4'b0001, 4'b1010};
        vecs[3] = '{4'b1111, 2'd1, 1'b0, 32'h0000_4440, 64'h5, 64'hCAFE, 4'b0000, 4'b0010, 4'b0000};
        vecs[4] = '{4'b0011, 2'd0, 1'b1, 32'h0000_0088, 64'hAAAA_5555_AAAA_5555, 64'h0, 4'b0100, 4'b0001, 4'b0100};
        vecs[5] = '{4'b0001, 2'd0, 1'b1, 32'h0000_0090, 64'h77, 64'h0, 4'b0001, 4'b0001, 4'b0000};
        vecs[6] = '{4'b1000, 2'd3, 1'b0, 32'hFFFF_FFFC, 64'h0, 64'h8000_0000_0000_0001, 4'b0000, 4'b1000, 4'b0000};
        vecs[7] = '{4'b0110, 2'd1, 1'b1, 32'h1234_5678, 64'h9, 64'h0, 4'b1111, 4'b0010, 4'b1101};
        rrOrder = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n        = 1'b0;
        req          = 4'b1111;
        req_we       = 4'd0;
        req_addr     = '0;
        req_wdata    = '0;
        l2_out       = '0;
        l2_sprocinfo = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_gnt", 64'(gnt), 64'h0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("rst_rsp_data", rsp_data, 64'h0);
        checkOutput("rst_inv_valid", 64'(inv_valid), 64'h0);
        checkOutput("rst_inv_mask", 64'(inv_mask), 64'h0);
        checkOutput("rst_inv_addr", 64'(inv_addr), 64'h0);
        checkOutput("rst_mode", 64'(l2_mode), 64'h1);
        checkOutput("rst_st", 64'(l2_st), 64'h0);
        checkOutput("rst_in", l2_in, 64'h0);
        checkOutput("rst_procinfo", 64'(l2_procinfo), 64'h0);
        checkOutput("rst_ch", 64'(l2_ch), 64'h0);

        // Round-robin with all four requests held from reset.
        rst_n = 1'b1;
        #1;
        cyc      = 0;
        nGrant   = 0;
        lastCyc  = 0;
        firstCyc = -1;
        while (nGrant < 5 && cyc < 60) begin
            if (gnt != 4'd0) begin
                checkOutput($sformatf("rr_gnt%0d", nGrant), 64'(gnt), 64'(rrOrder[nGrant]));
                if (nGrant == 0) firstCyc = cyc;
                else checkOutput($sformatf("rr_spacing%0d", nGrant), 64'(cyc - lastCyc), 64'(3 + L2_LAT));
                lastCyc = cyc;
                nGrant++;
            end
            if (nGrant < 5) begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("rr_grant_count", 64'(nGrant), 64'd5);
        checkOutput("rr_first_cycle", 64'(firstCyc), 64'd0);
        nextCycle();
        req = 4'd0;
        repeat (L2_LAT + 4) @(posedge clk);

        doReset();
        for (int i = 0; i < 8; i++) runVector(vecs[i], i);

        // Reset during WAIT; pointer is 2 here, so core 1 wins req=0010.
        applyStimulus(4'b0010, 1'b1, 2'd1, 32'h5555_0000, 64'h66);
        l2_sprocinfo = 4'b1111;
        @(negedge clk);
        checkOutput("mw_gnt", 64'(gnt), 64'b0010);
        nextCycle();
        req = 4'd0;
        @(negedge clk);
        checkOutput("mw_issue_procinfo", 64'(l2_procinfo), 64'h1);
        nextCycle();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mw_rst_mode", 64'(l2_mode), 64'h1);
        checkOutput("mw_rst_st", 64'(l2_st), 64'h0);
        checkOutput("mw_rst_in", l2_in, 64'h0);
        checkOutput("mw_rst_procinfo", 64'(l2_procinfo), 64'h0);
        checkOutput("mw_rst_rsp", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        sawRsp = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid != 4'd0 || inv_valid) sawRsp = 1'b1;
        end
        checkOutput("mw_no_rsp_after_reset", 64'(sawRsp), 64'h0);
        nextCycle();
        applyStimulus(4'b1010, 1'b0, 2'd1, 32'h0000_0100, 64'h0);
        @(negedge clk);
        checkOutput("mw_regrant_from_core0", 64'(gnt), 64'b0010);
        nextCycle();
        req = 4'd0;
        repeat (L2_LAT + 4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
